// File: rtl/obstacle_scheduler.sv
// ---------------------------------------------------------------------------
// obstacle_scheduler
//   Owns the ten obstacle slots that game_logic collides against. On every
//   frame tick while in-game it steps the spawn LFSR, scrolls live obstacles
//   left, retires the ones that have left the screen (counting them), and
//   every SPAWN_INTERVAL ticks drops a new obstacle at the right screen edge
//   into the lowest free slot, at a pseudo-random height.
//
//   gamemode | meaning
//   ---------+---------------------------------------------------------------
//   00       | initial: everything held at reset values, cleared every cycle
//   01       | in-game: frame_tick drives scroll / retire / spawn
//   10       | paused: all state frozen, frame_tick ignored
//   11       | ended: all state frozen, frame_tick ignored
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   gamemode    game phase from game_logic (table above)
//   frame_tick  one-cycle pulse per video frame
//   obstacle_x  slot k: [k*20+:10] left x, [k*20+10+:10] right x
//   obstacle_y  slot k: [k*18+:9] top y, [k*18+9+:9] bottom y
//   active      bit k set when slot k holds a live obstacle
//   passed_cnt  obstacles retired this game, saturating at 16'hFFFF
//   spawn_miss  one-cycle pulse when a spawn was due but every slot was busy
// ---------------------------------------------------------------------------
module obstacle_scheduler #(
  parameter int          SCREEN_W       = 640,
  parameter int          OBS_W          = 40,
  parameter int          OBS_H          = 80,
  parameter int          UPPER_BOUND    = 20,
  parameter int          SPEED          = 4,
  parameter int          SPAWN_INTERVAL = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   gamemode,
  input  logic         frame_tick,
  output logic [199:0] obstacle_x,
  output logic [179:0] obstacle_y,
  output logic [9:0]   active,
  output logic [15:0]  passed_cnt,
  output logic         spawn_miss
);

  localparam int N_SLOTS = 10;
  localparam int CNT_W   = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

  // Parked slots sit at the far corner so they can never overlap the player.
  localparam logic [9:0] X_PARK  = 10'd1023;
  localparam logic [8:0] Y_PARK  = 9'd511;
  localparam logic [9:0] SPEED_X = 10'(SPEED);
  localparam logic [9:0] SPAWN_L = 10'(SCREEN_W);
  localparam logic [9:0] SPAWN_R = 10'(SCREEN_W + OBS_W - 1);
  localparam logic [8:0] TOP_MIN = 9'(UPPER_BOUND);
  localparam logic [8:0] H_M1    = 9'(OBS_H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_PLAY  = 2'b01,
    GM_PAUSE = 2'b10,
    GM_END   = 2'b11
  } gamemode_e;

  logic [9:0]       left_q  [N_SLOTS];
  logic [9:0]       right_q [N_SLOTS];
  logic [8:0]       top_q   [N_SLOTS];
  logic [8:0]       bot_q   [N_SLOTS];
  logic [CNT_W-1:0] spawn_cnt;
  logic [15:0]      lfsr;

  logic             lfsr_fb;
  logic [9:0]       retire;
  logic [3:0]       retire_cnt;
  logic [16:0]      pc_sum;
  logic [15:0]      pc_next;
  logic             spawn_due;
  logic             any_free;
  logic [3:0]       free_idx;
  logic [8:0]       rnd;
  logic [8:0]       rnd_adj;
  logic [8:0]       spawn_top;

  always_comb begin
    // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10).
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    retire     = '0;
    retire_cnt = '0;
    free_idx   = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      retire[k]  = active[k] && (right_q[k] < SPEED_X);
      retire_cnt = retire_cnt + {3'b000, retire[k]};
    end
    // Free set is taken from active before this tick's retires, so a slot
    // retiring now cannot be reused on the same tick.
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (!active[k]) free_idx = 4'(k);
    end
    any_free  = ~&active;
    pc_sum    = {1'b0, passed_cnt} + {13'd0, retire_cnt};
    pc_next   = pc_sum[16] ? 16'hFFFF : pc_sum[15:0];
    spawn_due = (spawn_cnt == CNT_LAST);
    // Height comes from the LFSR value before this tick's step; folding
    // values above 360 down by 256 keeps the bottom edge on screen.
    rnd       = lfsr[8:0];
    rnd_adj   = (rnd > 9'd360) ? (rnd - 9'd256) : rnd;
    spawn_top = TOP_MIN + rnd_adj;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        left_q[k]  <= X_PARK;
        right_q[k] <= X_PARK;
        top_q[k]   <= Y_PARK;
        bot_q[k]   <= Y_PARK;
      end
      active     <= '0;
      passed_cnt <= '0;
      spawn_miss <= 1'b0;
      spawn_cnt  <= '0;
      lfsr       <= LFSR_SEED;
    end else if (gamemode == GM_INIT) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        left_q[k]  <= X_PARK;
        right_q[k] <= X_PARK;
        top_q[k]   <= Y_PARK;
        bot_q[k]   <= Y_PARK;
      end
      active     <= '0;
      passed_cnt <= '0;
      spawn_miss <= 1'b0;
      spawn_cnt  <= '0;
      lfsr       <= LFSR_SEED;
    end else if ((gamemode == GM_PLAY) && frame_tick) begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      spawn_miss <= 1'b0;
      passed_cnt <= pc_next;
      for (int k = 0; k < N_SLOTS; k++) begin
        if (retire[k]) begin
          left_q[k]  <= X_PARK;
          right_q[k] <= X_PARK;
          top_q[k]   <= Y_PARK;
          bot_q[k]   <= Y_PARK;
          active[k]  <= 1'b0;
        end else if (active[k]) begin
          right_q[k] <= right_q[k] - SPEED_X;
          left_q[k]  <= (left_q[k] < SPEED_X) ? 10'd0 : (left_q[k] - SPEED_X);
        end
      end
      if (spawn_due) begin
        spawn_cnt <= '0;
        // The chosen slot was inactive, so the scroll loop above never
        // touched it; these writes are the only ones to that slot.
        if (any_free) begin
          left_q[free_idx]  <= SPAWN_L;
          right_q[free_idx] <= SPAWN_R;
          top_q[free_idx]   <= spawn_top;
          bot_q[free_idx]   <= spawn_top + H_M1;
          active[free_idx]  <= 1'b1;
        end else begin
          spawn_miss <= 1'b1;
        end
      end else begin
        spawn_cnt <= spawn_cnt + CNT_W'(1);
      end
    end else begin
      spawn_miss <= 1'b0;
    end
  end

  always_comb begin
    obstacle_x = '0;
    obstacle_y = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      obstacle_x[k*20 +: 10]    = left_q[k];
      obstacle_x[k*20+10 +: 10] = right_q[k];
      obstacle_y[k*18 +: 9]     = top_q[k];
      obstacle_y[k*18+9 +: 9]   = bot_q[k];
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   gamemode;
  logic         frame_tick;
  logic [199:0] ox   [2];
  logic [179:0] oy   [2];
  logic [9:0]   act  [2];
  logic [15:0]  pc   [2];
  logic         miss [2];

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // Instance 0: default parameters. Instance 1: short screen, fast scroll and
  // a spawn on every tick, so slots fill up and spawn misses happen quickly.
  obstacle_scheduler dut_d (
    .clk(clk), .rst(rst), .gamemode(gamemode), .frame_tick(frame_tick),
    .obstacle_x(ox[0]), .obstacle_y(oy[0]), .active(act[0]),
    .passed_cnt(pc[0]), .spawn_miss(miss[0])
  );

  obstacle_scheduler #(.SCREEN_W(100), .SPEED(15), .SPAWN_INTERVAL(1)) dut_f (
    .clk(clk), .rst(rst), .gamemode(gamemode), .frame_tick(frame_tick),
    .obstacle_x(ox[1]), .obstacle_y(oy[1]), .active(act[1]),
    .passed_cnt(pc[1]), .spawn_miss(miss[1])
  );

  localparam int P_SW  [2] = '{640, 100};
  localparam int P_OW  [2] = '{40, 40};
  localparam int P_SPD [2] = '{4, 15};
  localparam int P_INT [2] = '{60, 1};
  localparam int OBS_H = 80;
  localparam int UPPER = 20;

  // Behavioural model: plain integers per slot.
  int m_l [2][10];
  int m_r [2][10];
  int m_t [2][10];
  int m_b [2][10];
  bit m_a [2][10];
  int m_pc   [2];
  int m_cnt  [2];
  int m_lfsr [2];
  bit m_miss [2];

  task automatic model_reset(input int i);
    for (int k = 0; k < 10; k++) begin
      m_l[i][k] = 1023; m_r[i][k] = 1023; m_t[i][k] = 511; m_b[i][k] = 511;
      m_a[i][k] = 1'b0;
    end
    m_pc[i] = 0; m_cnt[i] = 0; m_lfsr[i] = 'hACE1; m_miss[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input logic r, input logic [1:0] g, input logic t);
    int old;
    int fb;
    int nret;
    int j;
    int rr;
    bit fr [10];
    if (r || g == 2'b00) begin
      model_reset(i);
    end else if (g == 2'b01 && t) begin
      old = m_lfsr[i];
      fb = ((old >> 15) ^ (old >> 13) ^ (old >> 12) ^ (old >> 10)) & 1;
      m_lfsr[i] = ((old << 1) & 'hFFFF) | fb;
      for (int k = 0; k < 10; k++) fr[k] = !m_a[i][k];
      nret = 0;
      for (int k = 0; k < 10; k++) begin
        if (m_a[i][k]) begin
          if (m_r[i][k] < P_SPD[i]) begin
            m_l[i][k] = 1023; m_r[i][k] = 1023; m_t[i][k] = 511; m_b[i][k] = 511;
            m_a[i][k] = 1'b0;
            nret++;
          end else begin
            m_r[i][k] = m_r[i][k] - P_SPD[i];
            m_l[i][k] = (m_l[i][k] < P_SPD[i]) ? 0 : m_l[i][k] - P_SPD[i];
          end
        end
      end
      m_pc[i] = (m_pc[i] + nret > 65535) ? 65535 : m_pc[i] + nret;
      m_miss[i] = 1'b0;
      if (m_cnt[i] == P_INT[i] - 1) begin
        m_cnt[i] = 0;
        j = -1;
        for (int k = 0; k < 10; k++) if (fr[k] && j < 0) j = k;
        if (j < 0) begin
          m_miss[i] = 1'b1;
        end else begin
          rr = old & 'h1FF;
          if (rr > 360) rr = rr - 256;
          m_t[i][j] = UPPER + rr;
          m_b[i][j] = m_t[i][j] + OBS_H - 1;
          m_l[i][j] = P_SW[i];
          m_r[i][j] = P_SW[i] + P_OW[i] - 1;
          m_a[i][j] = 1'b1;
        end
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end else begin
      m_miss[i] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_inst(input int i);
    logic [199:0] ex;
    logic [179:0] ey;
    logic [9:0]   ea;
    for (int k = 0; k < 10; k++) begin
      ex[k*20 +: 10]    = 10'(m_l[i][k]);
      ex[k*20+10 +: 10] = 10'(m_r[i][k]);
      ey[k*18 +: 9]     = 9'(m_t[i][k]);
      ey[k*18+9 +: 9]   = 9'(m_b[i][k]);
      ea[k]             = m_a[i][k];
    end
    check($sformatf("obstacle_x[%0d]", i), ox[i], ex);
    check($sformatf("obstacle_y[%0d]", i), 200'(oy[i]), 200'(ey));
    check($sformatf("active[%0d]", i), 200'(act[i]), 200'(ea));
    check($sformatf("passed_cnt[%0d]", i), 200'(pc[i]), 200'(m_pc[i]));
    check($sformatf("spawn_miss[%0d]", i), 200'(miss[i]), 200'(m_miss[i]));
  endtask

  // One clock: inputs applied after a falling edge, model advanced at the
  // rising edge, outputs sampled 1 time unit later.
  task automatic cyc(input logic [1:0] g, input logic t, input logic r);
    gamemode = g; frame_tick = t; rst = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, r, g, t);
    #1;
    for (int i = 0; i < 2; i++) check_inst(i);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  gm;
    logic        tk;
    logic [9:0]  act;
    logic        miss;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [1:0] g, input logic t, input logic [9:0] a,
                              input logic m, input logic [15:0] p);
    vec_t v;
    v.gm = g; v.tk = t; v.act = a; v.miss = m; v.pc = p;
    return v;
  endfunction

  initial begin
    logic [1:0] g;
    logic       t;
    logic       r;
    int         w;

    // Fast instance: spawn on every tick, each obstacle retires on the
    // tenth tick after its spawn (right 139 -> 4 after nine scrolls of 15).
    tbl.push_back(mk(2'b00, 1'b0, 10'h000, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h001, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b0, 10'h001, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h003, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h007, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h00F, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h01F, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h03F, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h07F, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h0FF, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h1FF, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h3FF, 1'b0, 16'd0));
    tbl.push_back(mk(2'b01, 1'b1, 10'h3FE, 1'b1, 16'd1));
    tbl.push_back(mk(2'b01, 1'b0, 10'h3FE, 1'b0, 16'd1));
    tbl.push_back(mk(2'b01, 1'b1, 10'h3FD, 1'b0, 16'd2));
    tbl.push_back(mk(2'b01, 1'b1, 10'h3FB, 1'b0, 16'd3));
    tbl.push_back(mk(2'b10, 1'b1, 10'h3FB, 1'b0, 16'd3));
    tbl.push_back(mk(2'b11, 1'b1, 10'h3FB, 1'b0, 16'd3));
    tbl.push_back(mk(2'b01, 1'b1, 10'h3F7, 1'b0, 16'd4));
    tbl.push_back(mk(2'b00, 1'b0, 10'h000, 1'b0, 16'd0));

    rst = 1'b1; gamemode = 2'b00; frame_tick = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);
    @(negedge clk);

    // Reset state.
    cyc(2'b00, 1'b0, 1'b1);
    check("reset active", 200'(act[0]), 200'd0);
    check("reset obstacle_x parked", ox[0], {200{1'b1}});
    check("reset passed_cnt", 200'(pc[0]), 200'd0);
    cyc(2'b00, 1'b0, 1'b0);

    // First spawn of the default instance arrives on the 60th tick.
    for (int n = 1; n <= 59; n++) cyc(2'b01, 1'b1, 1'b0);
    check("no spawn before 60th tick", 200'(act[0]), 200'd0);
    cyc(2'b01, 1'b1, 1'b0);
    check("spawn active", 200'(act[0]), 200'd1);
    check("spawn left", 200'(ox[0][9:0]), 200'd640);
    check("spawn right", 200'(ox[0][19:10]), 200'd679);
    check("spawn top", 200'(oy[0][8:0]), 200'(m_t[0][0]));
    check("spawn bottom", 200'(oy[0][17:9]), 200'(m_t[0][0] + 79));

    // Table-driven sequence for the fast instance.
    foreach (tbl[n]) begin
      cyc(tbl[n].gm, tbl[n].tk, 1'b0);
      check($sformatf("tbl%0d active", n), 200'(act[1]), 200'(tbl[n].act));
      check($sformatf("tbl%0d spawn_miss", n), 200'(miss[1]), 200'(tbl[n].miss));
      check($sformatf("tbl%0d passed_cnt", n), 200'(pc[1]), 200'(tbl[n].pc));
    end

    // Build up state, pause for 100 ticks, then resume.
    for (int n = 0; n < 80; n++) cyc(2'b01, 1'b1, 1'b0);
    for (int n = 0; n < 100; n++) cyc(2'b10, 1'b1, 1'b0);
    check("pause keeps default obstacle", 200'(act[0]), 200'd1);
    for (int n = 0; n < 200; n++) cyc(2'b01, 1'b1, 1'b0);
    check("default obstacle retired", 200'(pc[0] != 16'd0), 200'd1);

    // Asynchronous reset between edges clears at once.
    #2 rst = 1'b1;
    #1;
    check("async rst active0", 200'(act[0]), 200'd0);
    check("async rst active1", 200'(act[1]), 200'd0);
    check("async rst passed1", 200'(pc[1]), 200'd0);
    check("async rst obstacle_x1", ox[1], {200{1'b1}});
    check("async rst obstacle_y1", 200'(oy[1]), 200'({180{1'b1}}));
    for (int i = 0; i < 2; i++) model_reset(i);
    @(negedge clk);
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 1'b0);

    // Randomized stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      w = int'($urandom_range(0, 999));
      if (w < 870)      g = 2'b01;
      else if (w < 940) g = 2'b10;
      else if (w < 998) g = 2'b11;
      else              g = 2'b00;
      t = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1999) == 0);
      cyc(g, t, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
